// File: rtl/mole_hit_judge.sv
// mole_hit_judge
// Consumer side of the whack-a-mole mole/LED interface. Requests a mole
// position from the RNG and latches it, then lights that mole. Debounced
// button presses are judged against the mole, and the block tracks score,
// lives and game-over.
//
// Build option: define WHACK_SPEEDUP_EN to make the mole window shrink by
// TIMEOUT_CYCLES/16 on every hit. The window never drops below
// TIMEOUT_CYCLES/4 and goes back to TIMEOUT_CYCLES on start. Without the
// macro the window is fixed at TIMEOUT_CYCLES and no window register exists.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, waiting for start, LEDs dark
// SPAWN   | mole_req high for this single cycle
// LATCH   | RNG output valid, capture mole index, clear timer
// ACTIVE  | mole lit, judge presses, count toward timeout
// GAP     | all LEDs dark for GAP_CYCLES before the next mole
// OVER    | lives exhausted, all LEDs lit, presses ignored until start

module mole_hit_judge #(
  parameter int N_HOLES        = 8,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int GAP_CYCLES     = 100,
  parameter int LIVES          = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W-1:0]   mole_idx,
  input  logic [N_HOLES-1:0] btn,
  output logic               mole_req,
  output logic [N_HOLES-1:0] led,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives_left,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]   GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SPAWN  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx_q;
  logic [TMR_W-1:0]   timer;
  logic [N_HOLES-1:0] btn_q;
  logic [N_HOLES-1:0] press_q;

  logic [N_HOLES-1:0] mole_mask;
  logic               wrong_press;
  logic               right_press;
  logic               time_up;
  logic               judge_hit;
  logic [TMR_W-1:0]   win_last;

  assign mole_mask   = N_HOLES'(1) << idx_q;
  assign wrong_press = |(press_q & ~mole_mask);
  assign right_press = |(press_q & mole_mask);
  assign time_up     = (timer == win_last);
  // Wrong presses take priority, so a hit needs the correct bit alone.
  assign judge_hit   = (state == S_ACTIVE) && !start && right_press && !wrong_press;

  assign mole_req  = (state == S_SPAWN);
  assign game_over = (state == S_OVER);

`ifdef WHACK_SPEEDUP_EN
  localparam int WIN_STEP  = TIMEOUT_CYCLES / 16;
  localparam int WIN_FLOOR = (TIMEOUT_CYCLES / 4 > 0) ? TIMEOUT_CYCLES / 4 : 1;

  localparam logic [TMR_W-1:0] WIN_FULL  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] WIN_MIN   = TMR_W'(WIN_FLOOR);
  localparam logic [TMR_W-1:0] WIN_DEC   = TMR_W'(WIN_STEP);
  localparam logic [TMR_W-1:0] WIN_KNEE  = TMR_W'(WIN_FLOOR + WIN_STEP);

  logic [TMR_W-1:0] win_q;

  assign win_last = win_q - TMR_W'(1);

  // Active window length: reloads on start, shrinks on each scored hit down to the floor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= WIN_FULL;
    end else if (start) begin
      win_q <= WIN_FULL;
    end else if (judge_hit) begin
      if (win_q >= WIN_KNEE) begin
        win_q <= win_q - WIN_DEC;
      end else begin
        win_q <= WIN_MIN;
      end
    end
  end
`else
  assign win_last = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

  // Rising-edge detect. It runs in every state, so a button held before
  // ACTIVE cannot show up as a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q   <= '0;
      press_q <= '0;
    end else begin
      btn_q   <= btn;
      press_q <= btn & ~btn_q;
    end
  end

  // Game sequencer: mole request/latch, judging, gap timing, score and lives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx_q      <= '0;
      timer      <= '0;
      score      <= '0;
      lives_left <= LIVES_INIT;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        state      <= S_SPAWN;
        timer      <= '0;
        score      <= '0;
        lives_left <= LIVES_INIT;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_SPAWN: begin
            state <= S_LATCH;
          end
          S_LATCH: begin
            idx_q <= IDX_W'(int'(mole_idx) % N_HOLES);
            timer <= '0;
            state <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (wrong_press || (!right_press && time_up)) begin
              miss_pulse <= 1'b1;
              if (lives_left != 4'd0) begin
                lives_left <= lives_left - 4'd1;
              end
              timer <= '0;
              state <= S_GAP;
            end else if (right_press) begin
              hit_pulse <= 1'b1;
              if (score != SCORE_MAX) begin
                score <= score + SCORE_W'(1);
              end
              timer <= '0;
              state <= S_GAP;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          S_GAP: begin
            if (timer == GAP_LAST) begin
              timer <= '0;
              state <= (lives_left != 4'd0) ? S_SPAWN : S_OVER;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          S_OVER: begin
            state <= S_OVER;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // LED drive: the single mole while active, everything lit once the game is over.
  always_comb begin
    led = '0;
    case (state)
      S_ACTIVE: led = mole_mask;
      S_OVER:   led = '1;
      default:  led = '0;
    endcase
  end

endmodule

// File: tb/tb_mole_hit_judge.sv
// Bench for mole_hit_judge with short timing parameters.
module tb_mole_hit_judge;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TO = 20;
  localparam int GP = 4;
  localparam int LV = 3;
  localparam int SW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [IW-1:0] mole_idx;
  logic [N-1:0]  btn;
  logic          mole_req;
  logic [N-1:0]  led;
  logic [SW-1:0] score;
  logic [3:0]    lives_left;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          game_over;

  mole_hit_judge #(
    .N_HOLES(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP),
    .LIVES(LV), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mole_idx(mole_idx), .btn(btn),
    .mole_req(mole_req), .led(led), .score(score), .lives_left(lives_left),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         st;
    logic [2:0] mole;
    logic [7:0] mask;
    int         d;
    bit         hold;
    bit         exp_hit;
    int         exp_score;
    int         exp_lives;
    bit         tmo;
  } vec_t;

  typedef struct {
    bit hit;
    bit miss;
    int score;
    int lives;
    int cyc;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   next_req = 0;
  int   win_m = TO;
  exp_t sb_q[$];
  vec_t tbl[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every hit/miss pulse must match the oldest queued expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (hit_pulse || miss_pulse) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {hit_pulse, miss_pulse}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("hit_pulse", hit_pulse, mon_e.hit);
        check("miss_pulse", miss_pulse, mon_e.miss);
        check("score", score, mon_e.score);
        check("lives_left", lives_left, mon_e.lives);
        check("led_dark_on_pulse", led, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    next_req = cyc + 1;
    step();
    start = 1'b0;
    win_m = TO;
  endtask

  task automatic wait_req();
    bit seen = 0;
    bit dirty = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (led != 0) dirty = 1;
      if (mole_req) seen = 1;
    end
    check("mole_req_seen", seen, 1);
    check("mole_req_cycle", cyc, next_req);
    check("led_dark_before_req", dirty, 0);
  endtask

  // Leaves the caller in the middle of the first ACTIVE cycle.
  task automatic enter_active(input logic [2:0] m, output int a);
    logic [7:0] one;
    one = 8'h01;
    step();
    mole_idx = m;
    @(negedge clk);
    check("mole_req_one_cycle", mole_req, 0);
    step();
    mole_idx = ~m;
    a = cyc;
    @(negedge clk);
    check("led_onehot", led, one << m);
  endtask

  task automatic do_round(input vec_t v);
    int   a;
    exp_t e;
    if (v.hold) btn = v.mask;
    wait_req();
    enter_active(v.mole, a);
    e.hit   = v.exp_hit;
    e.miss  = !v.exp_hit;
    e.score = v.exp_score;
    e.lives = v.exp_lives;
    e.cyc   = v.tmo ? a + win_m : a + v.d + 2;
    sb_q.push_back(e);
    for (int k = 0; k < v.d; k++) begin
      if (v.hold && k == v.d - 1) btn = '0;
      step();
    end
    btn = v.mask;
    step();
    btn = '0;
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) step();
    check("pulse_arrived", sb_q.size(), 0);
    sb_q.delete();
    next_req = e.cyc + GP;
`ifdef WHACK_SPEEDUP_EN
    if (v.exp_hit) win_m = (win_m - TO / 16 < TO / 4) ? TO / 4 : win_m - TO / 16;
`endif
  endtask

  task automatic over_checks(input int exp_score);
    bit req_seen = 0;
    repeat (GP + 2) step();
    @(negedge clk);
    check("game_over", game_over, 1);
    check("led_all_on", led, 8'hFF);
    step();
    btn = 8'hFF;
    step();
    btn = '0;
    step();
    btn = 8'h01;
    step();
    btn = '0;
    repeat (8) begin
      @(negedge clk);
      if (mole_req) req_seen = 1;
    end
    check("over_no_req", req_seen, 0);
    check("over_holds", game_over, 1);
    check("over_score", score, exp_score);
    check("over_lives", lives_left, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   a;
    vec_t v;
    bit   idle_bad;

    //            st mole   mask  d  hold hit score lives tmo
    tbl[0] = '{1, 3'd0, 8'h01, 18, 0, 1, 1, 3, 0};
    tbl[1] = '{0, 3'd4, 8'h10, 19, 0, 0, 1, 2, 1};
    tbl[2] = '{0, 3'd5, 8'h20,  0, 0, 1, 2, 2, 0};
    tbl[3] = '{0, 3'd2, 8'h44,  1, 0, 0, 2, 1, 0};
    tbl[4] = '{0, 3'd3, 8'h08,  6, 1, 1, 3, 1, 0};
    tbl[5] = '{0, 3'd7, 8'h80,  3, 0, 1, 4, 1, 0};
    tbl[6] = '{0, 3'd1, 8'h00,  0, 0, 0, 4, 0, 1};
    tbl[7] = '{1, 3'd6, 8'h01,  0, 0, 0, 0, 2, 0};
    tbl[8] = '{0, 3'd1, 8'h02,  4, 0, 1, 1, 2, 0};

    reset = 1'b0;
    start = 1'b0;
    mole_idx = '0;
    btn = '0;
    repeat (2) step();
    check("rst_led", led, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives_left, LV);
    check("rst_game_over", game_over, 0);
    check("rst_mole_req", mole_req, 0);
    check("rst_pulses", {hit_pulse, miss_pulse}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    check("idle_no_req", mole_req, 0);

    foreach (tbl[i]) begin
      if (tbl[i].st) pulse_start();
      do_round(tbl[i]);
      if (tbl[i].exp_lives == 0) over_checks(tbl[i].exp_score);
    end

    // Start in the middle of ACTIVE restarts the game without a pulse.
    wait_req();
    enter_active(3'd2, a);
    repeat (3) step();
    pulse_start();
    check("restart_score", score, 0);
    check("restart_lives", lives_left, LV);
    check("restart_led", led, 0);
    v = '{0, 3'd5, 8'h20, 2, 0, 1, 1, 3, 0};
    do_round(v);

    // Asynchronous reset in the middle of ACTIVE.
    wait_req();
    enter_active(3'd6, a);
    step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_led", led, 0);
    check("arst_score", score, 0);
    check("arst_lives", lives_left, LV);
    check("arst_game_over", game_over, 0);
    check("arst_mole_req", mole_req, 0);
    check("arst_pulses", {hit_pulse, miss_pulse}, 0);
    repeat (2) step();
    #3;
    reset = 1'b1;
    idle_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mole_req || led != 0) idle_bad = 1;
    end
    check("arst_stays_idle", idle_bad, 0);

`ifdef WHACK_SPEEDUP_EN
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      v = '{0, 3'(i % 8), 8'h01 << (i % 8), 0, 0, 1, i + 1, 3, 0};
      do_round(v);
    end
    v = '{0, 3'd2, 8'h00, 0, 0, 0, 16, 2, 1};
    do_round(v);
    pulse_start();
    v = '{0, 3'd3, 8'h00, 0, 0, 0, 0, 2, 1};
    do_round(v);
`endif

    repeat (3) step();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
